leftunpad: RTL and testbench
============================

# leftunpad

Stream-side inverse of the leftpad block: consumes a left-padded character stream one character per accepted cycle, discards the leading run of pad characters, buffers the remaining string, and replays it character by character once the stream ends. It sits on the receive side of a leftpad link. It also reports how many pad characters were stripped, so a consumer can check the padding against the expected width.

## Interface
- STR_LEN_MAX, 8: maximum stored string length in characters; must be ≥ 2.
- CHAR_W, 8: character width in bits.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high. Also latches `cpad`.
- cpad  input  CHAR_W  pad character; sampled only on a `rst` cycle.
- in_en  input  1  `cin`/`in_last` valid this cycle.
- cin  input  CHAR_W  input stream character.
- in_last  input  1  marks the final stream character; qualified by `in_en`.
- cout  output  CHAR_W  output string character; `'0` whenever `out_en` = 0.
- out_en  output  1  `cout` valid this cycle.
- outlen  output  $clog2(STR_LEN_MAX+1)  number of stored characters (stripped length, saturated).
- padcnt  output  $clog2(2*STR_LEN_MAX)  leading pad characters stripped; saturates at all-ones.
- ovf  output  1  sticky; set if any non-stripped character was dropped because the buffer was full.
- done  output  1  high in ST_DIS; the stream has been fully consumed and replayed.

## Operation
- Reset cycle: latch `cpad` into `cpad_la`; state ← ST_SKIP; clear the write index, read index, outlen, padcnt, ovf and buffer index state. Buffer contents are don't-care.
- Reset values of outputs, visible from the cycle after `rst`: out_en=0, cout='0, outlen=0, padcnt=0, ovf=0, done=0.
- Internal state: `str[STR_LEN_MAX]` buffer, write index `wr`, read index `rd`.
- State machine: ST_SKIP → ST_STORE → ST_OUT → ST_DIS. ST_STORE and ST_OUT may each be bypassed. There is no return to an earlier state except through `rst`.
- ST_SKIP, `in_en`=1:
  - If cin == cpad_la: drop the character; padcnt += 1 (saturating).
  - Otherwise: store at str[wr]; wr += 1; outlen += 1; go to ST_STORE.
  - The first non-pad character ends skipping permanently. Later pad characters are data.
- ST_STORE, `in_en`=1: store every character.
  - If wr == STR_LEN_MAX: drop the character, set ovf, hold outlen at STR_LEN_MAX.
- `in_en`=1 with in_last=1 in ST_SKIP or ST_STORE: the character is processed as above in the same cycle. Next state is ST_OUT if the resulting outlen > 0, else ST_DIS.
- `in_en`=0: no change. `in_last` is ignored when `in_en`=0.
- ST_OUT: out_en=1 and cout=str[rd]; rd += 1 each cycle. When rd+1 == outlen, go to ST_DIS.
- ST_DIS: out_en=0, done=1. outlen, padcnt and ovf hold until `rst`.
- Inputs are ignored in ST_OUT and ST_DIS.
- Width rules:
  - outlen counts up to and including STR_LEN_MAX.
  - padcnt saturates at 2^$clog2(2*STR_LEN_MAX)-1 and never wraps.
  - Index compares are done at width ≥ $clog2(STR_LEN_MAX+1) so there is no wrap at wr == STR_LEN_MAX.

## Timing
- Characters are accepted in the cycle they are presented with `in_en`=1; there is no backpressure.
- Final character accepted at cycle t with outlen = L > 0:
  - out_en=1 on cycles t+1 … t+L, emitting str[0] … str[L-1] in input order.
  - done=1 from cycle t+L+1.
- Final character accepted at cycle t with L = 0 (empty or all-pad stream): out_en is never asserted; done=1 from cycle t+1.
- outlen, padcnt and ovf are registered. Each reflects the characters accepted through cycle t-1 at cycle t.
- `rst` asserted in any state, including mid-output: the next cycle shows reset values and ST_SKIP. Partial output is abandoned and the new `cpad` applies.
- `rst` and `in_en` in the same cycle: `rst` wins and the character is discarded.

## Test plan
- cpad="!", stream "!!foo" with in_last on the final 'o' → out_en for 3 cycles starting the next cycle; cout "f","o","o"; padcnt=2, outlen=3, ovf=0; done on the following cycle.
- cpad="!", stream "!!!" with in_last → out_en never asserted; done the cycle after the last character; padcnt=3, outlen=0.
- cpad="!", stream "!a!b" → replay "a","!","b"; padcnt=1, outlen=3 (interior pad is kept).
- STR_LEN_MAX=8, ten characters "abcdefghij" with no pad → replay "abcdefgh" only; outlen=8, ovf=1.
- Stream "xy" with in_en=0 bubbles between characters and an in_last pulse during a bubble → bubbles and the unqualified in_last are ignored; replay "x","y" only after in_last arrives qualified by in_en.
- `rst` during the second ST_OUT cycle with cpad="?" → next cycle out_en=0, all counters 0, done=0; a following stream "?z" replays "z" with padcnt=1.

Source files
------------

// File: rtl/leftunpad_if.sv
// Stream bus for the leftunpad block: padded input
// stream plus replayed string and status outputs.
interface leftunpad_if #(
    parameter int STR_LEN_MAX = 8,
    parameter int CHAR_W      = 8
);
    localparam int LW = $clog2(STR_LEN_MAX + 1);
    localparam int PW = $clog2(2 * STR_LEN_MAX);

    logic [CHAR_W-1:0] cpad;
    logic              in_en;
    logic [CHAR_W-1:0] cin;
    logic              in_last;
    logic [CHAR_W-1:0] cout;
    logic              out_en;
    logic [LW-1:0]     outlen;
    logic [PW-1:0]     padcnt;
    logic              ovf;
    logic              done;

    modport master (
        output cpad, in_en, cin, in_last,
        input  cout, out_en, outlen, padcnt, ovf, done
    );

    modport slave (
        input  cpad, in_en, cin, in_last,
        output cout, out_en, outlen, padcnt, ovf, done
    );
endinterface

// File: rtl/leftunpad.sv
// Strips the leading pad run from a character stream,
// buffers the rest and replays it once the stream ends.
module leftunpad #(
    parameter int STR_LEN_MAX = 8,
    parameter int CHAR_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    leftunpad_if.slave  bus
);
    localparam int LW = $clog2(STR_LEN_MAX + 1);
    localparam int PW = $clog2(2 * STR_LEN_MAX);
    localparam int IW = $clog2(STR_LEN_MAX);

    typedef enum logic [1:0] {
        ST_SKIP,
        ST_STORE,
        ST_OUT,
        ST_DIS
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CHAR_W-1:0] r_cpad;
    logic [CHAR_W-1:0] r_str [STR_LEN_MAX];
    logic [LW-1:0]     r_wr;
    logic [LW-1:0]     r_rd;
    logic [PW-1:0]     r_padcnt;
    logic              r_ovf;

    logic              w_is_pad;
    logic              w_full;
    logic              w_store;
    logic              w_pad_inc;
    logic              w_ovf_set;
    logic [LW-1:0]     w_len_nxt;

    // Only the leading run is stripped; later pads are data
    assign w_is_pad = (r_state == ST_SKIP) && (bus.cin == r_cpad);
    assign w_full   = (r_wr == LW'(STR_LEN_MAX));

    // State register and counters; wr doubles as outlen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_SKIP;
            r_cpad   <= bus.cpad;
            r_wr     <= '0;
            r_rd     <= '0;
            r_padcnt <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_store)
                r_wr <= r_wr + LW'(1);
            if (r_state == ST_OUT)
                r_rd <= r_rd + LW'(1);
            if (w_pad_inc && (r_padcnt != '1))
                r_padcnt <= r_padcnt + PW'(1);
            if (w_ovf_set)
                r_ovf <= 1'b1;
        end
    end

    // String buffer; contents need no reset
    always_ff @(posedge clk) begin
        if (!rst && w_store)
            r_str[r_wr[IW-1:0]] <= bus.cin;
    end

    // Next-state and per-character accept decisions
    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_pad_inc   = 1'b0;
        w_ovf_set   = 1'b0;
        w_len_nxt   = r_wr;
        unique case (r_state)
            ST_SKIP, ST_STORE: begin
                if (bus.in_en) begin
                    if (w_is_pad) begin
                        w_pad_inc = 1'b1;
                    end else if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_store   = 1'b1;
                        w_len_nxt = r_wr + LW'(1);
                    end
                    if (bus.in_last)
                        w_state_nxt = (w_len_nxt != '0) ? ST_OUT : ST_DIS;
                    else if (!w_is_pad)
                        w_state_nxt = ST_STORE;
                end
            end
            ST_OUT: begin
                if ((r_rd + LW'(1)) == r_wr)
                    w_state_nxt = ST_DIS;
            end
            ST_DIS: begin
                w_state_nxt = ST_DIS;
            end
            default: begin
                w_state_nxt = ST_SKIP;
            end
        endcase
    end

    assign bus.out_en = (r_state == ST_OUT);
    assign bus.cout   = bus.out_en ? r_str[r_rd[IW-1:0]] : '0;
    assign bus.done   = (r_state == ST_DIS);
    assign bus.outlen = r_wr;
    assign bus.padcnt = r_padcnt;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_leftunpad.sv
// Directed bench for leftunpad: table of streams with
// expected replay plus hand-written reset/bubble cases.
module tb_leftunpad;
    localparam int SLM = 8;
    localparam int CW  = 8;

    logic clk;
    logic rst;

    leftunpad_if #(.STR_LEN_MAX(SLM), .CHAR_W(CW)) bus ();

    leftunpad #(.STR_LEN_MAX(SLM), .CHAR_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]          cpad;
        logic [31:0][7:0]    stream;
        int                  nin;
        logic [7:0][7:0]     expout;
        int                  nout;
        int                  exppad;
        int                  explen;
        logic                expovf;
    } vec_t;

    vec_t vt [7];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] cp);
        rst          = 1'b1;
        bus.cpad     = cp;
        bus.in_en    = 1'b0;
        bus.in_last  = 1'b0;
        bus.cin      = '0;
        tick();
        rst          = 1'b0;
        chk("reset_state",
            64'({bus.out_en, bus.cout, bus.outlen,
                 bus.padcnt, bus.ovf, bus.done}), 64'd0);
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        bus.in_en   = 1'b1;
        bus.cin     = c;
        bus.in_last = last;
        tick();
        bus.in_en   = 1'b0;
        bus.in_last = 1'b0;
        bus.cin     = '0;
    endtask

    task automatic expect_char(input string name, input logic [7:0] c);
        chk({name, "_out_en"}, 64'(bus.out_en), 64'd1);
        chk({name, "_cout"}, 64'(bus.cout), 64'(c));
        chk({name, "_done_low"}, 64'(bus.done), 64'd0);
        tick();
    endtask

    task automatic expect_end(input string name, input int pad,
                              input int len, input logic ov);
        chk({name, "_done"}, 64'(bus.done), 64'd1);
        chk({name, "_out_idle"}, 64'({bus.out_en, bus.cout}), 64'd0);
        chk({name, "_padcnt"}, 64'(bus.padcnt), 64'(pad));
        chk({name, "_outlen"}, 64'(bus.outlen), 64'(len));
        chk({name, "_ovf"}, 64'(bus.ovf), 64'(ov));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.cpad    = "!";
        bus.in_en   = 1'b0;
        bus.cin     = '0;
        bus.in_last = 1'b0;

        vt[0] = '{"!", 256'("!!foo"), 5, 64'("foo"), 3, 2, 3, 1'b0};
        vt[1] = '{"!", 256'("!!!"), 3, 64'd0, 0, 3, 0, 1'b0};
        vt[2] = '{"!", 256'("!a!b"), 4, 64'("a!b"), 3, 1, 3, 1'b0};
        vt[3] = '{"!", 256'("abcdefghij"), 10, 64'("abcdefgh"),
                  8, 0, 8, 1'b1};
        vt[4] = '{"!", 256'("abcdefgh"), 8, 64'("abcdefgh"),
                  8, 0, 8, 1'b0};
        vt[5] = '{"-", 256'("--------------------q"), 21, 64'("q"),
                  1, 15, 1, 1'b0};
        vt[6] = '{"!", 256'("z"), 1, 64'("z"), 1, 0, 1, 1'b0};

        tick();

        for (int v = 0; v < 7; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            do_reset(vt[v].cpad);
            for (int i = 0; i < vt[v].nin; i++)
                send(vt[v].stream[vt[v].nin - 1 - i], i == vt[v].nin - 1);
            for (int k = 0; k < vt[v].nout; k++)
                expect_char($sformatf("%s_c%0d", nm, k),
                            vt[v].expout[vt[v].nout - 1 - k]);
            expect_end(nm, vt[v].exppad, vt[v].explen, vt[v].expovf);
        end

        do_reset("!");
        send("x", 1'b0);
        tick();
        bus.in_last = 1'b1;
        tick();
        bus.in_last = 1'b0;
        chk("bubble_no_out", 64'({bus.out_en, bus.done}), 64'd0);
        tick();
        chk("bubble_outlen", 64'(bus.outlen), 64'd1);
        send("y", 1'b1);
        expect_char("bubble_c0", "x");
        expect_char("bubble_c1", "y");
        expect_end("bubble", 0, 2, 1'b0);

        do_reset("!");
        send("a", 1'b0);
        send("b", 1'b1);
        expect_char("rstmid_c0", "a");
        chk("rstmid_c1", 64'({bus.out_en, bus.cout}), 64'({1'b1, 8'("b")}));
        rst         = 1'b1;
        bus.cpad    = "?";
        bus.in_en   = 1'b1;
        bus.cin     = "k";
        tick();
        rst         = 1'b0;
        bus.in_en   = 1'b0;
        bus.cin     = '0;
        chk("rstmid_cleared",
            64'({bus.out_en, bus.cout, bus.outlen,
                 bus.padcnt, bus.ovf, bus.done}), 64'd0);
        send("?", 1'b0);
        send("z", 1'b1);
        expect_char("rstmid_z", "z");
        expect_end("rstmid", 1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
